// File: rtl/mips_pkg.sv
// Shared definitions for the 5-stage MIPS core.
//   - LD_*     : load-type encodings carried on m_ld_type
//   - WD_*     : write-back source encodings carried on m_wd_sel
//   - RESET_PC : PC value held in pipeline registers after reset or flush
//   - w_regs_t : field bundle held in the M->W pipeline register
package mips_pkg;

    localparam logic [2:0] LD_LW  = 3'd0;
    localparam logic [2:0] LD_LB  = 3'd1;
    localparam logic [2:0] LD_LBU = 3'd2;
    localparam logic [2:0] LD_LH  = 3'd3;
    localparam logic [2:0] LD_LHU = 3'd4;

    localparam logic [1:0] WD_ALU = 2'd0;
    localparam logic [1:0] WD_MEM = 2'd1;
    localparam logic [1:0] WD_PC8 = 2'd2;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic        reg_we;
        logic [4:0]  a3;
        logic [1:0]  wd_sel;
        logic [31:0] alu_res;
        logic [31:0] dm_rdata;
        logic [2:0]  ld_type;
        logic [1:0]  addr_lo;
    } w_regs_t;

endpackage

// File: rtl/load_ext.sv
// Load data extraction and extension.
// Ports:
//   rdata_i   : raw aligned 32-bit word from data memory
//   addr_lo_i : low two bits of the byte address
//   ld_type_i : load type (LD_* encodings; unknown codes behave as LW)
//   ext_o     : extracted, sign- or zero-extended 32-bit result
module load_ext
    import mips_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [2:0]  ld_type_i,
    output logic [31:0] ext_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata_i[{addr_lo_i, 3'b000} +: 8];
        // Halfword loads are assumed aligned; addr_lo_i[0] is ignored.
        half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

        case (ld_type_i)
            LD_LB:   ext_o = {{24{byte_sel[7]}}, byte_sel};
            LD_LBU:  ext_o = {24'h000000, byte_sel};
            LD_LH:   ext_o = {{16{half_sel[15]}}, half_sel};
            LD_LHU:  ext_o = {16'h0000, half_sel};
            default: ext_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mw_wb_stage.sv
// M->W pipeline register and write-back datapath.
// Captures M-stage results each rising edge (priority reset > flush > stall > load), extracts
// and extends load data, selects write-back data, and drives the register-file write port.
// Ports:
//   clk, reset           : clock; synchronous active-high reset
//   stall, flush         : hold all W registers / load a bubble (flush wins)
//   m_*                  : M-stage instruction fields
//   w_pc/w_we/w_a3/w_wd  : register-file write port (WPC, WE3, A3, WD3)
//   w_fwd_a3/w_fwd_wd    : forwarding address (0 when no write) and data
//   w_retired            : count of valid instructions captured into W (wraps)
module mw_wb_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] PC8_OFFSET = 32'd8,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             flush,
    input  logic             m_valid,
    input  logic [31:0]      m_pc,
    input  logic             m_reg_we,
    input  logic [4:0]       m_a3,
    input  logic [1:0]       m_wd_sel,
    input  logic [31:0]      m_alu_res,
    input  logic [31:0]      m_dm_rdata,
    input  logic [2:0]       m_ld_type,
    output logic [31:0]      w_pc,
    output logic             w_we,
    output logic [4:0]       w_a3,
    output logic [31:0]      w_wd,
    output logic [4:0]       w_fwd_a3,
    output logic [31:0]      w_fwd_wd,
    output logic [CNT_W-1:0] w_retired
);

    localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

    w_regs_t          w_q, w_d, bubble;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      ld_data;

    always_comb begin
        bubble    = '0;
        bubble.pc = RESET_PC;
    end

    // Next-state: flush beats stall; the counter only advances on a real load of a valid instr.
    always_comb begin
        w_d   = w_q;
        cnt_d = cnt_q;
        if (flush) begin
            w_d = bubble;
        end else if (!stall) begin
            w_d.valid    = m_valid;
            w_d.pc       = m_pc;
            w_d.reg_we   = m_reg_we;
            w_d.a3       = m_a3;
            w_d.wd_sel   = m_wd_sel;
            w_d.alu_res  = m_alu_res;
            w_d.dm_rdata = m_dm_rdata;
            w_d.ld_type  = m_ld_type;
            w_d.addr_lo  = m_alu_res[1:0];
            if (m_valid) begin
                cnt_d = cnt_q + CntOne;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            w_q   <= bubble;
            cnt_q <= '0;
        end else begin
            w_q   <= w_d;
            cnt_q <= cnt_d;
        end
    end

    load_ext u_load_ext (
        .rdata_i   (w_q.dm_rdata),
        .addr_lo_i (w_q.addr_lo),
        .ld_type_i (w_q.ld_type),
        .ext_o     (ld_data)
    );

    always_comb begin
        case (w_q.wd_sel)
            WD_ALU:  w_wd = w_q.alu_res;
            WD_MEM:  w_wd = ld_data;
            WD_PC8:  w_wd = w_q.pc + PC8_OFFSET;
            default: w_wd = 32'h0000_0000;
        endcase
    end

    // $0 is hard-wired zero, so a write to it is suppressed entirely.
    assign w_we      = w_q.valid & w_q.reg_we & (w_q.a3 != 5'd0);
    assign w_pc      = w_q.pc;
    assign w_a3      = w_q.a3;
    assign w_fwd_a3  = w_we ? w_q.a3 : 5'd0;
    assign w_fwd_wd  = w_wd;
    assign w_retired = cnt_q;

endmodule

// File: tb/tb_mw_wb_stage.sv
module tb_mw_wb_stage;

    logic        clk = 1'b0;
    logic        reset, stall, flush, m_valid, m_reg_we;
    logic [31:0] m_pc, m_alu_res, m_dm_rdata;
    logic [4:0]  m_a3;
    logic [1:0]  m_wd_sel;
    logic [2:0]  m_ld_type;

    logic [31:0] w_pc, w_wd, w_fwd_wd;
    logic        w_we;
    logic [4:0]  w_a3, w_fwd_a3;
    logic [31:0] w_retired;

    logic [31:0] u4_pc, u4_wd, u4_fwd_wd;
    logic        u4_we;
    logic [4:0]  u4_a3, u4_fwd_a3;
    logic [3:0]  u4_retired;

    int errors = 0;
    int checks = 0;

    // Reference state: the captured instruction and a plain retired count.
    bit          r_valid, r_we;
    bit [31:0]   r_pc, r_alu, r_rdata;
    bit [4:0]    r_a3;
    bit [1:0]    r_sel;
    bit [2:0]    r_ld;
    longint unsigned r_cnt;

    always #5 clk = ~clk;

    mw_wb_stage #(.PC8_OFFSET(32'd8), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .m_valid(m_valid),
        .m_pc(m_pc), .m_reg_we(m_reg_we), .m_a3(m_a3), .m_wd_sel(m_wd_sel),
        .m_alu_res(m_alu_res), .m_dm_rdata(m_dm_rdata), .m_ld_type(m_ld_type),
        .w_pc(w_pc), .w_we(w_we), .w_a3(w_a3), .w_wd(w_wd), .w_fwd_a3(w_fwd_a3),
        .w_fwd_wd(w_fwd_wd), .w_retired(w_retired)
    );

    mw_wb_stage #(.PC8_OFFSET(32'd8), .CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .m_valid(m_valid),
        .m_pc(m_pc), .m_reg_we(m_reg_we), .m_a3(m_a3), .m_wd_sel(m_wd_sel),
        .m_alu_res(m_alu_res), .m_dm_rdata(m_dm_rdata), .m_ld_type(m_ld_type),
        .w_pc(u4_pc), .w_we(u4_we), .w_a3(u4_a3), .w_wd(u4_wd), .w_fwd_a3(u4_fwd_a3),
        .w_fwd_wd(u4_fwd_wd), .w_retired(u4_retired)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Load result from the ISA rules: shift the lane down, mask, add sign bits arithmetically.
    function automatic bit [31:0] ref_load(bit [31:0] d, bit [1:0] lo, bit [2:0] t);
        bit [31:0] b, h;
        b = (d >> (8 * lo)) & 32'hFF;
        h = (d >> (16 * (lo / 2))) & 32'hFFFF;
        case (t)
            3'd1:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
            3'd2:    return b;
            3'd3:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
            3'd4:    return h;
            default: return d;
        endcase
    endfunction

    function automatic bit [31:0] ref_wd();
        if (r_sel == 2'd0) return r_alu;
        if (r_sel == 2'd1) return ref_load(r_rdata, r_alu[1:0], r_ld);
        if (r_sel == 2'd2) return r_pc + 32'd8;
        return 32'd0;
    endfunction

    task automatic model_clear();
        r_valid = 0; r_we = 0; r_pc = 0; r_alu = 0; r_rdata = 0;
        r_a3 = 0; r_sel = 0; r_ld = 0;
    endtask

    // Advance model with the current inputs, then clock the DUTs and settle.
    task automatic tick();
        if (reset) begin
            model_clear();
            r_cnt = 0;
        end else if (flush) begin
            model_clear();
        end else if (!stall) begin
            r_valid = m_valid; r_we = m_reg_we; r_pc = m_pc; r_alu = m_alu_res;
            r_rdata = m_dm_rdata; r_a3 = m_a3; r_sel = m_wd_sel; r_ld = m_ld_type;
            if (m_valid) r_cnt++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag);
        bit e_we;
        e_we = r_valid && r_we && (r_a3 != 0);
        chk({tag, ".w_pc"}, w_pc, r_pc);
        chk({tag, ".w_we"}, {31'd0, w_we}, {31'd0, e_we});
        chk({tag, ".w_a3"}, {27'd0, w_a3}, {27'd0, r_a3});
        chk({tag, ".w_wd"}, w_wd, ref_wd());
        chk({tag, ".w_fwd_a3"}, {27'd0, w_fwd_a3}, e_we ? {27'd0, r_a3} : 32'd0);
        chk({tag, ".w_fwd_wd"}, w_fwd_wd, ref_wd());
        chk({tag, ".w_retired"}, w_retired, r_cnt[31:0]);
        chk({tag, ".retired4"}, {28'd0, u4_retired}, r_cnt % 16);
    endtask

    task automatic drive(input bit v, input bit we, input bit [4:0] a3, input bit [1:0] sel,
                         input bit [31:0] alu, input bit [31:0] rd, input bit [2:0] ld,
                         input bit [31:0] pc);
        m_valid = v; m_reg_we = we; m_a3 = a3; m_wd_sel = sel;
        m_alu_res = alu; m_dm_rdata = rd; m_ld_type = ld; m_pc = pc;
    endtask

    typedef struct { bit [2:0] ld; bit [1:0] lo; bit [31:0] exp; } ld_vec_t;
    ld_vec_t ld_vecs[5];
    bit [31:0] held_pc;

    initial begin
        ld_vecs[0] = '{3'd1, 2'd3, 32'hFFFF_FF80};
        ld_vecs[1] = '{3'd2, 2'd3, 32'h0000_0080};
        ld_vecs[2] = '{3'd3, 2'd2, 32'hFFFF_80FF};
        ld_vecs[3] = '{3'd4, 2'd0, 32'h0000_7F01};
        ld_vecs[4] = '{3'd0, 2'd0, 32'h80FF_7F01};

        reset = 1; stall = 0; flush = 0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        model_clear(); r_cnt = 0;
        tick(); tick();
        reset = 0;

        // Reset then idle.
        for (int i = 0; i < 3; i++) begin
            tick();
            check_all("idle");
            chk("idle.w_wd0", w_wd, 32'd0);
        end

        // ALU write.
        drive(1, 1, 5'd8, 2'd0, 32'h1234_5678, 32'h0, 3'd0, 32'h3000);
        tick();
        check_all("alu");
        chk("alu.wd", w_wd, 32'h1234_5678);
        chk("alu.we", {31'd0, w_we}, 32'd1);
        chk("alu.retired", w_retired, 32'd1);

        // Load extension vectors.
        foreach (ld_vecs[i]) begin
            drive(1, 1, 5'd9, 2'd1, {30'h0000_1000, ld_vecs[i].lo}, 32'h80FF_7F01,
                  ld_vecs[i].ld, 32'h3004);
            tick();
            check_all("ld");
            chk($sformatf("ld%0d.wd", i), w_wd, ld_vecs[i].exp);
        end

        // Link write and write to $0.
        drive(1, 1, 5'd31, 2'd2, 32'h0, 32'h0, 3'd0, 32'h3010);
        tick();
        check_all("link");
        chk("link.wd", w_wd, 32'h3018);
        drive(1, 1, 5'd0, 2'd2, 32'h0, 32'h0, 3'd0, 32'h3010);
        tick();
        check_all("zero");
        chk("zero.we", {31'd0, w_we}, 32'd0);
        chk("zero.fwd_a3", {27'd0, w_fwd_a3}, 32'd0);

        // Stall holds everything while M inputs change.
        drive(1, 1, 5'd5, 2'd0, 32'hCAFE_0000, 32'h0, 3'd0, 32'h4000);
        tick();
        held_pc = w_pc;
        stall = 1;
        drive(1, 1, 5'd6, 2'd0, 32'hDEAD_BEEF, 32'h0, 3'd0, 32'h5000);
        for (int i = 0; i < 2; i++) begin
            tick();
            check_all("stall");
            chk("stall.pc", w_pc, held_pc);
        end

        // Flush and stall together: bubble, counter unchanged.
        flush = 1;
        tick();
        check_all("flush_stall");
        chk("flush.pc", w_pc, 32'd0);
        chk("flush.we", {31'd0, w_we}, 32'd0);
        flush = 0;

        // Reload, then reset while stalled.
        stall = 0;
        tick();
        stall = 1; reset = 1;
        tick();
        check_all("reset_stall");
        chk("reset_stall.retired", w_retired, 32'd0);
        reset = 0; stall = 0;

        // Counter wrap on the 4-bit instance, with interleaved invalid cycles.
        for (int i = 0; i < 16; i++) begin
            drive(1, 1, 5'd3, 2'd0, i, 32'h0, 3'd0, 32'h100 + 4 * i);
            tick();
            check_all("wrap");
            drive(0, 1, 5'd3, 2'd0, i, 32'h0, 3'd0, 32'h0);
            tick();
            check_all("wrap_idle");
        end
        chk("wrap.retired4", {28'd0, u4_retired}, 32'd0);
        chk("wrap.retired32", w_retired, 32'd16);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 99) < 2);
            flush = ($urandom_range(0, 99) < 10);
            stall = ($urandom_range(0, 99) < 15);
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                  ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
                  2'($urandom), $urandom, $urandom, 3'($urandom), $urandom);
            tick();
            check_all("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
